// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Access sizes, FSM states and the per-size byte mask.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        SzB = 2'd0,
        SzH = 2'd1,
        SzW = 2'd2,
        SzD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } lsu_state_e;

    // Byte mask of an access of the given size, right-justified.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            SzB:     mask = 8'h01;
            SzH:     mask = 8'h03;
            SzW:     mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_lsu_lane_align.sv
// Byte-lane steering for the load/store unit: byte enables, store-data
// replication and load-data extraction with sign/zero extension.
module mem_lsu_lane_align #(
    parameter int unsigned XLEN       = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic [$clog2(XLEN/8)-1:0] offset_i,
    input  logic [1:0]                size_i,
    input  logic                      sign_ext_i,
    input  logic [XLEN-1:0]           wdata_i,
    input  logic [XLEN-1:0]           rdata_i,
    output logic [XLEN/8-1:0]         be_o,
    output logic [XLEN-1:0]           wdata_o,
    output logic [XLEN-1:0]           load_data_o
);
    import mem_lsu_pkg::*;

    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);

    logic [OFF_W-1:0] lane;
    logic [BE_W-1:0]  mask;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  bitmask;
    logic             msb;

    always_comb begin
        mask = BE_W'(size_mask(size_i));
        // Big-endian puts the lowest address in the most significant lane.
        if (BIG_ENDIAN) begin
            lane = OFF_W'(BE_W - 32'(offset_i) - (32'd1 << size_i));
        end else begin
            lane = offset_i;
        end
        be_o = mask << lane;
    end

    always_comb begin
        case (size_i)
            SzB:     wdata_o = {BE_W{wdata_i[7:0]}};
            SzH:     wdata_o = {(BE_W / 2){wdata_i[15:0]}};
            SzW:     wdata_o = {(BE_W / 4){wdata_i[31:0]}};
            default: wdata_o = wdata_i;
        endcase
    end

    always_comb begin
        shifted = rdata_i >> {lane, 3'b000};
        for (int i = 0; i < BE_W; i++) begin
            bitmask[8*i +: 8] = {8{mask[i]}};
        end
        case (size_i)
            SzB:     msb = shifted[7];
            SzH:     msb = shifted[15];
            SzW:     msb = shifted[31];
            default: msb = shifted[XLEN-1];
        endcase
        load_data_o = (shifted & bitmask) | ((sign_ext_i && msb) ? ~bitmask : '0);
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: request FSM, LL/SC link tracking and the
// registered completion outputs consumed by MEM/WB.
module mem_lsu #(
    parameter int unsigned XLEN       = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                op_valid_i,
    input  logic                mem_read_i,
    input  logic                mem_write_i,
    input  logic [1:0]          mem_size_i,
    input  logic                mem_sign_extend_i,
    input  logic                llsc_i,
    input  logic [XLEN-1:0]     addr_i,
    input  logic [XLEN-1:0]     wdata_i,
    output logic                stall_controller_o,
    output logic                done_o,
    output logic [XLEN-1:0]     load_data_o,
    output logic                addr_error_o,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [XLEN-1:0]     dmem_addr_o,
    output logic [XLEN/8-1:0]   dmem_be_o,
    output logic [XLEN-1:0]     dmem_wdata_o,
    input  logic                dmem_gnt_i,
    input  logic                dmem_rvalid_i,
    input  logic [XLEN-1:0]     dmem_rdata_i
);
    import mem_lsu_pkg::*;

    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [1:0]      size_q, size_d;
    logic            sign_q, sign_d;
    logic            we_q, we_d;
    logic            llsc_q, llsc_d;
    logic            link_valid_q, link_valid_d;
    logic [XLEN-1:0] link_addr_q, link_addr_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic            addr_error_q, addr_error_d;

    logic            go;
    logic            misaligned;
    logic            sc_ok;
    logic            sc_fail;
    logic            accept;
    logic            complete;
    logic [XLEN-1:0] word_addr_q;
    logic [BE_W-1:0] lane_be;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] lane_load;

    always_comb begin
        case (mem_size_i)
            SzB:     misaligned = 1'b0;
            SzH:     misaligned = addr_i[0];
            SzW:     misaligned = |addr_i[1:0];
            default: misaligned = (XLEN == 64) ? |addr_i[2:0] : 1'b1;
        endcase
    end

    // New work is only considered in IDLE; flush and reset both veto it.
    assign go = (state_q == StIdle) & op_valid_i & (mem_read_i | mem_write_i)
              & ~flush_i & ~rst_i;
    assign sc_ok = link_valid_q && (link_addr_q == {addr_i[XLEN-1:2], 2'b00});
    assign sc_fail = go & ~misaligned & mem_write_i & llsc_i & ~sc_ok;
    assign accept = go & ~misaligned & ~sc_fail;
    assign complete = ~flush_i & dmem_rvalid_i
                    & ((state_q == StWait) | ((state_q == StReq) & dmem_gnt_i));
    assign word_addr_q = {addr_q[XLEN-1:2], 2'b00};

    mem_lsu_lane_align #(
        .XLEN       (XLEN),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_align (
        .offset_i    (addr_q[OFF_W-1:0]),
        .size_i      (size_q),
        .sign_ext_i  (sign_q),
        .wdata_i     (wdata_q),
        .rdata_i     (dmem_rdata_i),
        .be_o        (lane_be),
        .wdata_o     (lane_wdata),
        .load_data_o (lane_load)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) state_d = StReq;
            end
            StReq: begin
                // A grant racing the flush leaves a response to absorb.
                if (flush_i) begin
                    state_d = (dmem_gnt_i && !dmem_rvalid_i) ? StDrain : StIdle;
                end else if (dmem_gnt_i) begin
                    state_d = dmem_rvalid_i ? StIdle : StWait;
                end
            end
            StWait: begin
                if (dmem_rvalid_i) begin
                    state_d = StIdle;
                end else if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (dmem_rvalid_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall_controller_o = 1'b0;
        dmem_req_o         = 1'b0;
        dmem_we_o          = 1'b0;
        dmem_addr_o        = '0;
        dmem_be_o          = '0;
        dmem_wdata_o       = '0;
        case (state_q)
            StIdle: stall_controller_o = accept;
            StReq: begin
                dmem_req_o         = 1'b1;
                dmem_we_o          = we_q;
                dmem_addr_o        = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                dmem_be_o          = lane_be;
                dmem_wdata_o       = we_q ? lane_wdata : '0;
                stall_controller_o = ~flush_i & ~(dmem_gnt_i & dmem_rvalid_i);
            end
            StWait: stall_controller_o = ~flush_i & ~dmem_rvalid_i;
            default: stall_controller_o = 1'b0;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        sign_d       = sign_q;
        we_d         = we_q;
        llsc_d       = llsc_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        done_d       = sc_fail;
        load_data_d  = '0;
        addr_error_d = go & misaligned;
        if (accept) begin
            addr_d  = addr_i;
            wdata_d = wdata_i;
            size_d  = mem_size_i;
            sign_d  = mem_sign_extend_i;
            we_d    = mem_write_i;
            llsc_d  = llsc_i;
        end
        if (complete) begin
            done_d      = 1'b1;
            load_data_d = we_q ? XLEN'(llsc_q) : lane_load;
            if (!we_q && llsc_q) begin
                link_valid_d = 1'b1;
                link_addr_d  = word_addr_q;
            end else if (we_q && (llsc_q || word_addr_q == link_addr_q)) begin
                link_valid_d = 1'b0;
            end
        end
        if (flush_i) link_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            sign_q       <= 1'b0;
            we_q         <= 1'b0;
            llsc_q       <= 1'b0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            done_q       <= 1'b0;
            load_data_q  <= '0;
            addr_error_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            we_q         <= we_d;
            llsc_q       <= llsc_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            done_q       <= done_d;
            load_data_q  <= load_data_d;
            addr_error_q <= addr_error_d;
        end
    end

    assign done_o       = done_q;
    assign load_data_o  = load_data_q;
    assign addr_error_o = addr_error_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: three configurations (32-bit LE, 32-bit BE,
// 64-bit LE) share one stimulus stream; completions are scored from a queue.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        op_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic        sign = 1'b0;
    logic        llsc = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [63:0] rdata = '0;

    logic        stall_le, done_le, err_le, req_le, we_le;
    logic [31:0] ld_le, daddr_le, dwd_le;
    logic [3:0]  be_le;
    logic        stall_be, done_be, err_be, req_be, we_be;
    logic [31:0] ld_be, daddr_be, dwd_be;
    logic [3:0]  be_be;
    logic        stall_64, done_64, err_64, req_64, we_64;
    logic [63:0] ld_64, daddr_64, dwd_64;
    logic [7:0]  be_64;

    int          sel = 0;
    logic        mon_done, mon_stall, mon_req, mon_err, mon_we;
    logic [63:0] mon_ld, mon_wdata;
    logic [7:0]  mon_be;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    mem_lsu #(.XLEN(32), .BIG_ENDIAN(1'b0)) u_le (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .op_valid_i(op_valid),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .mem_size_i(mem_size),
        .mem_sign_extend_i(sign), .llsc_i(llsc), .addr_i(addr[31:0]), .wdata_i(wdata[31:0]),
        .stall_controller_o(stall_le), .done_o(done_le), .load_data_o(ld_le),
        .addr_error_o(err_le), .dmem_req_o(req_le), .dmem_we_o(we_le),
        .dmem_addr_o(daddr_le), .dmem_be_o(be_le), .dmem_wdata_o(dwd_le),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata[31:0])
    );

    mem_lsu #(.XLEN(32), .BIG_ENDIAN(1'b1)) u_be (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .op_valid_i(op_valid),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .mem_size_i(mem_size),
        .mem_sign_extend_i(sign), .llsc_i(llsc), .addr_i(addr[31:0]), .wdata_i(wdata[31:0]),
        .stall_controller_o(stall_be), .done_o(done_be), .load_data_o(ld_be),
        .addr_error_o(err_be), .dmem_req_o(req_be), .dmem_we_o(we_be),
        .dmem_addr_o(daddr_be), .dmem_be_o(be_be), .dmem_wdata_o(dwd_be),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata[31:0])
    );

    mem_lsu #(.XLEN(64), .BIG_ENDIAN(1'b0)) u_64 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .op_valid_i(op_valid),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .mem_size_i(mem_size),
        .mem_sign_extend_i(sign), .llsc_i(llsc), .addr_i(addr), .wdata_i(wdata),
        .stall_controller_o(stall_64), .done_o(done_64), .load_data_o(ld_64),
        .addr_error_o(err_64), .dmem_req_o(req_64), .dmem_we_o(we_64),
        .dmem_addr_o(daddr_64), .dmem_be_o(be_64), .dmem_wdata_o(dwd_64),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata)
    );

    always_comb begin
        mon_done  = done_le;
        mon_stall = stall_le;
        mon_req   = req_le;
        mon_err   = err_le;
        mon_we    = we_le;
        mon_ld    = {32'd0, ld_le};
        mon_wdata = {32'd0, dwd_le};
        mon_be    = {4'd0, be_le};
        if (sel == 1) begin
            mon_done  = done_be;
            mon_stall = stall_be;
            mon_req   = req_be;
            mon_err   = err_be;
            mon_we    = we_be;
            mon_ld    = {32'd0, ld_be};
            mon_wdata = {32'd0, dwd_be};
            mon_be    = {4'd0, be_be};
        end else if (sel == 2) begin
            mon_done  = done_64;
            mon_stall = stall_64;
            mon_req   = req_64;
            mon_err   = err_64;
            mon_we    = we_64;
            mon_ld    = ld_64;
            mon_wdata = dwd_64;
            mon_be    = be_64;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_op();
        op_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        llsc      = 1'b0;
        sign      = 1'b0;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic sx, input logic ll, input logic [63:0] a,
                            input logic [63:0] wd);
        op_valid  = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        mem_size  = sz;
        sign      = sx;
        llsc      = ll;
        addr      = a;
        wdata     = wd;
    endtask

    // Waits (bounded) for done on the monitored DUT and scores load_data.
    task automatic wait_done(input string tag);
        logic [63:0] exp;
        int n;
        n = 0;
        @(negedge clk);
        while (!mon_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check({tag, "_done"}, 64'(mon_done), 64'd1);
        check({tag, "_data"}, mon_ld, exp);
        step();
    endtask

    // Full access: grant on the first REQ cycle, response on the next.
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sx, input logic ll, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] resp,
                          input logic [63:0] exp, input string tag);
        drive_op(rd, wr, sz, sx, ll, a, wd);
        step();
        gnt = 1'b1;
        step();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = resp;
        sb.push_back(exp);
        step();
        rvalid = 1'b0;
        clear_op();
        wait_done(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_req", 64'(req_le), 64'd0);
        check("rst_stall", 64'(stall_le), 64'd0);
        check("rst_done", 64'(done_le), 64'd0);
        check("rst_err", 64'(err_le), 64'd0);
        step();
        rst = 1'b0;
        step();

        // 1: LE lb 0x103, sign-extended
        sel = 0;
        drive_op(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 64'h103, 64'h0);
        @(negedge clk);
        check("t1_stall_idle", 64'(mon_stall), 64'd1);
        step();
        gnt = 1'b1;
        @(negedge clk);
        check("t1_req", 64'(mon_req), 64'd1);
        check("t1_be", 64'(mon_be), 64'h08);
        check("t1_addr", 64'(daddr_le), 64'h100);
        step();
        gnt = 1'b0;
        @(negedge clk);
        check("t1_stall_wait", 64'(mon_stall), 64'd1);
        step();
        rvalid = 1'b1;
        rdata  = 64'h0000_0000_80AA_BBCC;
        @(negedge clk);
        check("t1_stall_rvalid", 64'(mon_stall), 64'd0);
        sb.push_back(64'h0000_0000_FFFF_FF80);
        step();
        rvalid = 1'b0;
        clear_op();
        wait_done("t1_lb");

        // 2: BE sh 0x202
        sel = 1;
        drive_op(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 64'h202, 64'h1234);
        step();
        gnt = 1'b1;
        @(negedge clk);
        check("t2_be", 64'(mon_be), 64'h03);
        check("t2_wdata", mon_wdata, 64'h1234_1234);
        check("t2_we", 64'(mon_we), 64'd1);
        check("t2_le_be", 64'(be_le), 64'h0C);
        step();
        gnt = 1'b0;
        @(negedge clk);
        check("t2_nodone_wait", 64'(mon_done), 64'd0);
        step();
        rvalid = 1'b1;
        sb.push_back(64'd0);
        step();
        rvalid = 1'b0;
        clear_op();
        wait_done("t2_sh");

        // 3: misaligned lw
        sel = 0;
        drive_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 64'h101, 64'h0);
        @(negedge clk);
        check("t3_stall", 64'(mon_stall), 64'd0);
        check("t3_req0", 64'(mon_req), 64'd0);
        step();
        clear_op();
        @(negedge clk);
        check("t3_err", 64'(mon_err), 64'd1);
        check("t3_req1", 64'(mon_req), 64'd0);
        step();
        @(negedge clk);
        check("t3_err_pulse", 64'(mon_err), 64'd0);
        step();

        // 4: LL/SC success, then SC broken by an intervening store
        access(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 64'h400, 64'h0, 64'hDEAD_BEEF,
               64'hDEAD_BEEF, "t4_ll");
        access(1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 64'h400, 64'h5, 64'h0, 64'd1, "t4_sc_ok");
        access(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 64'h400, 64'h0, 64'h1111_2222,
               64'h1111_2222, "t4_ll2");
        access(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 64'h400, 64'h7, 64'h0, 64'd0, "t4_sw");
        drive_op(1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 64'h400, 64'h9);
        @(negedge clk);
        check("t4_scf_stall", 64'(mon_stall), 64'd0);
        check("t4_scf_req", 64'(mon_req), 64'd0);
        sb.push_back(64'd0);
        step();
        clear_op();
        wait_done("t4_sc_fail");

        // 5: flush in REQ after 5 cycles of no grant, then flush in WAIT
        drive_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 64'h500, 64'h0);
        step();
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        check("t5_req_held", 64'(mon_req), 64'd1);
        step();
        flush = 1'b1;
        @(negedge clk);
        check("t5_flush_stall", 64'(mon_stall), 64'd0);
        step();
        flush = 1'b0;
        clear_op();
        @(negedge clk);
        check("t5_idle_req", 64'(mon_req), 64'd0);
        check("t5_nodone0", 64'(mon_done), 64'd0);
        step();
        drive_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 64'h504, 64'h0);
        step();
        gnt = 1'b1;
        step();
        gnt   = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("t5_wflush_stall", 64'(mon_stall), 64'd0);
        step();
        flush = 1'b0;
        clear_op();
        @(negedge clk);
        check("t5_drain_stall", 64'(mon_stall), 64'd0);
        step();
        rvalid = 1'b1;
        @(negedge clk);
        check("t5_drain_nodone", 64'(mon_done), 64'd0);
        step();
        rvalid = 1'b0;
        @(negedge clk);
        check("t5_drain_nodone2", 64'(mon_done), 64'd0);
        step();
        access(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 64'h508, 64'h0, 64'hCAFE_F00D,
               64'hCAFE_F00D, "t5_after_drain");

        // 6: 64-bit ld; same op is an illegal size on 32-bit
        sel = 2;
        drive_op(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 64'h8, 64'h0);
        step();
        gnt = 1'b1;
        @(negedge clk);
        check("t6_be", 64'(mon_be), 64'hFF);
        check("t6_addr", daddr_64, 64'h8);
        check("t6_err32", 64'(err_le), 64'd1);
        check("t6_req32", 64'(req_le), 64'd0);
        step();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 64'h0123_4567_89AB_CDEF;
        sb.push_back(64'h0123_4567_89AB_CDEF);
        step();
        rvalid = 1'b0;
        clear_op();
        wait_done("t6_ld");

        // Reset while waiting for the response
        drive_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 64'h10, 64'h0);
        step();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        @(negedge clk);
        check("t6_wait_stall", 64'(stall_64), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_stall64", 64'(stall_64), 64'd0);
        check("t6_rst_req64", 64'(req_64), 64'd0);
        check("t6_rst_be64", 64'(be_64), 64'd0);
        check("t6_rst_stall32", 64'(stall_le), 64'd0);
        check("t6_rst_done", 64'(done_64), 64'd0);
        clear_op();
        step();
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
